bird_plotter: RTL and testbench

BIRD_PLOTTER -- requirements
Module: bird_plotter

---
 rtl/bird_plotter.sv | 200 ++++++++++++++++++++
 tb/tb_bird_plotter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bird_plotter.sv
// Frame-based sprite plotter: each start erases every visible bird, advances the
// enabled ones by STEP (with wrap), then redraws them one pixel per cycle.
module bird_plotter #(
  parameter int          NUM_BIRDS = 4,
  parameter int          STEP      = 1,
  parameter int          X_MAX     = 159,
  parameter int          Y_MAX     = 119,
  parameter logic [2:0]  COLOUR    = 3'b111
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [NUM_BIRDS-1:0]     bird_en,
  input  logic [7*NUM_BIRDS-1:0]   bird_y,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [2:0]               colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     done,
  output logic [8*NUM_BIRDS-1:0]   bird_x
);

  localparam int SW = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;
  localparam logic signed [8:0] XM = 9'(X_MAX);
  localparam logic signed [8:0] YM = 9'(Y_MAX);
  localparam logic [3:0] LAST_PIX = 4'd12;

  typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          slot_q, slot_d;
  logic [3:0]             pix_q, pix_d;
  logic [7:0]             pos_x_q [NUM_BIRDS];
  logic [7:0]             pos_x_d [NUM_BIRDS];
  logic [6:0]             pos_y_q [NUM_BIRDS];
  logic [6:0]             pos_y_d [NUM_BIRDS];
  logic [6:0]             y_lat_q [NUM_BIRDS];
  logic [6:0]             y_lat_d [NUM_BIRDS];
  logic [NUM_BIRDS-1:0]   vis_q, vis_d;
  logic [NUM_BIRDS-1:0]   en_q, en_d;

  logic [SW:0]            first_old, next_vis, first_new;
  logic signed [3:0]      dx, dy;
  logic signed [8:0]      px, py;
  logic                   on_screen;

  // Returns {found, index} of the lowest set bit of mask at or above 'from'.
  function automatic logic [SW:0] first_from(input logic [NUM_BIRDS-1:0] mask,
                                             input int from);
    logic [SW:0] res;
    res = '0;
    for (int i = NUM_BIRDS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) res = {1'b1, SW'(i)};
    end
    return res;
  endfunction

  function automatic logic [7:0] advance(input logic [7:0] p);
    logic [8:0] sum;
    sum = {1'b0, p} + 9'(STEP);
    if (sum > 9'(X_MAX)) sum = sum - 9'(X_MAX + 1);
    return sum[7:0];
  endfunction

  function automatic logic signed [3:0] sprite_dx(input logic [3:0] p);
    case (p)
      4'd2:                sprite_dx = -4'sd1;
      4'd3:                sprite_dx = -4'sd2;
      4'd4, 4'd7, 4'd8:    sprite_dx = -4'sd3;
      4'd5, 4'd9, 4'd10:   sprite_dx = -4'sd4;
      4'd6, 4'd11, 4'd12:  sprite_dx = -4'sd5;
      default:             sprite_dx = 4'sd0;
    endcase
  endfunction

  function automatic logic signed [3:0] sprite_dy(input logic [3:0] p);
    case (p)
      4'd1, 4'd7:  sprite_dy = 4'sd1;
      4'd8:        sprite_dy = -4'sd1;
      4'd9:        sprite_dy = 4'sd2;
      4'd10:       sprite_dy = -4'sd2;
      4'd11:       sprite_dy = 4'sd3;
      4'd12:       sprite_dy = -4'sd3;
      default:     sprite_dy = 4'sd0;
    endcase
  endfunction

  assign first_old = first_from(vis_q, 0);
  assign next_vis  = first_from(vis_q, int'(slot_q) + 1);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    pix_d     = pix_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    y_lat_d   = y_lat_q;
    vis_d     = vis_q;
    en_d      = en_q;
    first_new = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          en_d  = bird_en;
          pix_d = '0;
          for (int i = 0; i < NUM_BIRDS; i++) y_lat_d[i] = bird_y[7*i +: 7];
          // Invisible birds cost no cycles, so with nothing on screen ERASE is skipped.
          if (first_old[SW]) begin
            state_d = ERASE;
            slot_d  = first_old[SW-1:0];
          end else begin
            state_d = MOVE;
          end
        end
      end
      ERASE, DRAW: begin
        if (pix_q == LAST_PIX) begin
          pix_d = '0;
          if (next_vis[SW]) slot_d = next_vis[SW-1:0];
          else              state_d = (state_q == ERASE) ? MOVE : DONE;
        end else begin
          pix_d = pix_q + 4'd1;
        end
      end
      MOVE: begin
        for (int i = 0; i < NUM_BIRDS; i++) begin
          if (en_q[i]) begin
            pos_x_d[i] = advance(pos_x_q[i]);
            pos_y_d[i] = y_lat_q[i];
            vis_d[i]   = 1'b1;
          end else begin
            vis_d[i]   = 1'b0;
          end
        end
        first_new = first_from(vis_d, 0);
        pix_d     = '0;
        if (first_new[SW]) begin
          state_d = DRAW;
          slot_d  = first_new[SW-1:0];
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      slot_q  <= '0;
      pix_q   <= '0;
      vis_q   <= '0;
      en_q    <= '0;
      for (int i = 0; i < NUM_BIRDS; i++) begin
        pos_x_q[i] <= '0;
        pos_y_q[i] <= '0;
        y_lat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      pix_q   <= pix_d;
      vis_q   <= vis_d;
      en_q    <= en_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      y_lat_q <= y_lat_d;
    end
  end

  // Pixel coordinates are signed so sprite parts hanging off the left/top edge clip cleanly.
  always_comb begin
    dx        = sprite_dx(pix_q);
    dy        = sprite_dy(pix_q);
    px        = $signed({1'b0, pos_x_q[slot_q]}) + {{5{dx[3]}}, dx};
    py        = $signed({2'b00, pos_y_q[slot_q]}) + {{5{dy[3]}}, dy};
    on_screen = !px[8] && (px <= XM) && !py[8] && (py <= YM);
    plot      = 1'b0;
    x         = '0;
    y         = '0;
    colour    = '0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    if ((state_q == ERASE || state_q == DRAW) && on_screen) begin
      plot   = 1'b1;
      x      = px[7:0];
      y      = py[6:0];
      colour = (state_q == DRAW) ? COLOUR : 3'b000;
    end
  end

  always_comb begin
    bird_x = '0;
    for (int i = 0; i < NUM_BIRDS; i++) bird_x[8*i +: 8] = pos_x_q[i];
  end

endmodule

// File: tb/tb_bird_plotter.sv
// Directed bench for bird_plotter: logs every cycle of a frame, then compares
// the log against hand-computed pixel sequences and latencies.
module tb_bird_plotter;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [3:0]  bird_en;
  logic [27:0] bird_y;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;
  logic [31:0] bird_x;

  int nChecks = 0;
  int nFails  = 0;
  int doneAt;

  logic       lp [256];
  logic [7:0] lx [256];
  logic [6:0] ly [256];
  logic [2:0] lc [256];

  logic [12:0] exp0;
  logic [12:0] exp1;
  logic        quiet;

  bird_plotter dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .bird_en(bird_en),
    .bird_y (bird_y),
    .x      (x),
    .y      (y),
    .colour (colour),
    .plot   (plot),
    .busy   (busy),
    .done   (done),
    .bird_x (bird_x)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, expv);
    end
  endtask

  // Issues one start and records every cycle up to done; glitch>0 re-pulses start mid-frame.
  task automatic applyStimulus(input logic [3:0] en, input logic [27:0] yv, input int glitch);
    bird_en = en;
    bird_y  = yv;
    start   = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
    bird_en = 4'b1111;
    bird_y  = '1;
    doneAt  = -1;
    for (int n = 0; n < 256; n++) lp[n] = 1'b0;
    for (int n = 1; n < 256; n++) begin
      start = (n == glitch);
      @(negedge clock);
      lp[n] = plot;
      lx[n] = x;
      ly[n] = y;
      lc[n] = colour;
      if (done) begin
        doneAt = n;
        break;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    @(posedge clock); #1;
  endtask

  function automatic int sumPlot(input int a, input int b);
    int s;
    s = 0;
    for (int i = a; i <= b; i++) s += int'(lp[i]);
    return s;
  endfunction

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    bird_en = '0;
    bird_y  = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_plot", 32'(plot), 0);
    checkOutput("rst_xyc", {x, 1'b0, y, 13'd0, colour}, 0);
    checkOutput("rst_bird_x", bird_x, 0);
    resetn = 1'b1;
    @(posedge clock); #1;

    $display("[TB] first frame");
    applyStimulus(4'b0001, 28'd10, 0);
    checkOutput("f1_done_at", doneAt, 15);
    checkOutput("f1_move_noplot", 32'(lp[1]), 0);
    checkOutput("f1_px0_plot", 32'(lp[2]), 1);
    checkOutput("f1_px0_x", 32'(lx[2]), 1);
    checkOutput("f1_px0_y", 32'(ly[2]), 10);
    checkOutput("f1_px0_col", 32'(lc[2]), 7);
    checkOutput("f1_px2_x", 32'(lx[4]), 0);
    checkOutput("f1_px3_offscreen", 32'(lp[5]), 0);
    checkOutput("f1_px3_x_zero", 32'(lx[5]), 0);
    checkOutput("f1_plot_count", sumPlot(1, 15), 3);
    checkOutput("f1_bird_x", 32'(bird_x[7:0]), 1);
    checkOutput("f1_idle_after", 32'(busy), 0);

    $display("[TB] second frame");
    applyStimulus(4'b0001, 28'd10, 0);
    checkOutput("f2_done_at", doneAt, 28);
    checkOutput("f2_erase_plot", 32'(lp[1]), 1);
    checkOutput("f2_erase_x", 32'(lx[1]), 1);
    checkOutput("f2_erase_col", 32'(lc[1]), 0);
    checkOutput("f2_move_noplot", 32'(lp[14]), 0);
    checkOutput("f2_draw_x", 32'(lx[15]), 2);
    checkOutput("f2_draw_col", 32'(lc[15]), 7);
    checkOutput("f2_plot_count", sumPlot(1, 28), 7);
    checkOutput("f2_bird_x", 32'(bird_x[7:0]), 2);

    $display("[TB] advancing to the right edge");
    for (int f = 0; f < 157; f++) applyStimulus(4'b0001, 28'd10, 0);
    checkOutput("edge_bird_x", 32'(bird_x[7:0]), 159);
    applyStimulus(4'b0001, 28'd10, 0);
    checkOutput("wrap_done_at", doneAt, 28);
    checkOutput("wrap_bird_x", 32'(bird_x[7:0]), 0);
    checkOutput("wrap_erase_x", 32'(lx[1]), 159);
    checkOutput("wrap_draw_px0", 32'(lp[15]), 1);
    checkOutput("wrap_draw_x", 32'(lx[15]), 0);
    checkOutput("wrap_dx_neg_plots", sumPlot(17, 27), 0);

    $display("[TB] disable slot, start while busy");
    applyStimulus(4'b0000, 28'd10, 5);
    checkOutput("dis_done_at", doneAt, 15);
    checkOutput("dis_erase_plot", 32'(lp[1]), 1);
    checkOutput("dis_erase_col", 32'(lc[1]), 0);
    checkOutput("dis_plot_count", sumPlot(1, 15), 2);
    checkOutput("dis_idle_after", 32'(busy), 0);
    @(posedge clock); #1;
    checkOutput("dis_no_queued_start", 32'(busy), 0);

    $display("[TB] top and bottom clipping");
    exp0 = 13'b1010101111101;
    exp1 = 13'b0101111111111;
    for (int f = 0; f < 6; f++) applyStimulus(4'b0011, {14'd0, 7'd1, 7'd119}, 0);
    checkOutput("clip_done_at", doneAt, 54);
    checkOutput("clip_bird_x1", 32'(bird_x[15:8]), 6);
    for (int i = 0; i < 13; i++) begin
      checkOutput($sformatf("clip_s0_px%0d", i), 32'(lp[28 + i]), 32'(exp0[i]));
      checkOutput($sformatf("clip_s1_px%0d", i), 32'(lp[41 + i]), 32'(exp1[i]));
    end
    checkOutput("clip_s0_off_y_zero", 32'(ly[29]), 0);
    checkOutput("clip_s0_px6_x", 32'(lx[34]), 1);
    checkOutput("clip_s1_px0_x", 32'(lx[41]), 6);
    checkOutput("clip_s1_px0_y", 32'(ly[41]), 1);
    checkOutput("clip_s1_px11_y", 32'(ly[52]), 4);

    $display("[TB] reset during draw");
    bird_en = 4'b0001;
    bird_y  = 28'd10;
    start   = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
    repeat (29) begin
      @(posedge clock); #1;
    end
    checkOutput("abort_busy_before", 32'(busy), 1);
    resetn = 1'b0;
    @(posedge clock); #1;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_plot", 32'(plot), 0);
    checkOutput("abort_done", 32'(done), 0);
    resetn = 1'b1;
    quiet  = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (done || plot || busy) quiet = 1'b0;
    end
    checkOutput("abort_quiet", 32'(quiet), 1);
    @(posedge clock); #1;
    applyStimulus(4'b0001, 28'd10, 0);
    checkOutput("post_rst_done_at", doneAt, 15);
    checkOutput("post_rst_px0_x", 32'(lx[2]), 1);
    checkOutput("post_rst_bird_x", 32'(bird_x[7:0]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
